board_debug_display: RTL and testbench
======================================

BOARD_DEBUG_DISPLAY -- requirements
Module: board_debug_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of 7-segment digits driven.
REQ-002 SHALL have parameter NUM_PAGES, default 4, number of selectable data pages (2..16).
REQ-003 SHALL have parameter TICK_DIV, default 50000, i_clk cycles per 1 ms tick.
REQ-004 SHALL have parameter DEBOUNCE_MS, default 20, ticks a button level must be stable to be accepted.
REQ-005 SHALL have parameter PAGE_MS, default 2000, ticks between automatic page advances.
REQ-006 SHALL have parameter BLINK_MS, default 250, ticks per blink half-period (used only with the blink option).
REQ-007 SHALL have port i_clk  input  1  single clock for all logic.
REQ-008 SHALL have port i_rstn  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port i_page_data  input  NUM_PAGES*NUM_DIGITS*4  nibbles; page p digit d at bits [(p*NUM_DIGITS+d)*4 +: 4].
REQ-010 SHALL have port i_btn_next_n  input  1  raw asynchronous push button, active-low, advances page.
REQ-011 SHALL have port i_auto  input  1  level; 1 enables automatic page rotation.
REQ-012 SHALL have port i_freeze  input  1  level; 1 holds the displayed snapshot.
REQ-013 SHALL have port o_hex  output  NUM_DIGITS*7  segments, active-low, digit d at [d*7 +: 7], bit0=a..bit6=g.
REQ-014 SHALL have port o_page_led  output  NUM_PAGES  one-hot current page indicator.
REQ-015 SHALL have port o_frozen  output  1  1 while snapshot held.

Function
REQ-016 SHALL generate a 1-cycle tick every TICK_DIV cycles from a free-running prescaler.
REQ-017 SHALL pass i_btn_next_n through a 2-flop synchronizer before any other use.
REQ-018 SHALL accept a new synchronized button level only after it has been stable for DEBOUNCE_MS consecutive ticks; any change restarts the count.
REQ-019 SHALL produce one page-advance event on each accepted 1->0 transition of the debounced button; holding the button produces no further events.
REQ-020 SHALL, while i_auto=1, produce a page-advance event every PAGE_MS ticks; the auto counter clears when i_auto=0 and on any button event.
REQ-021 SHALL advance the page index by exactly one when button and auto events coincide in the same cycle.
REQ-022 SHALL wrap the page index from NUM_PAGES-1 to 0.
REQ-023 SHALL ignore page-advance events while frozen.
REQ-024 SHALL, on the cycle i_freeze is first seen high, latch the current page's NUM_DIGITS nibbles into a snapshot; o_frozen=1 from the next cycle.
REQ-025 SHALL, on i_freeze low, display live data again from the next cycle and set o_frozen=0.
REQ-026 SHALL register o_hex: data/page state at cycle N appears on o_hex at cycle N+1.
REQ-027 SHALL encode nibbles 0-F as standard hex glyphs (e.g. 0->7'h40, 8->7'h00, F->7'h0E, active-low).
REQ-028 SHALL update o_page_led in the same cycle as o_hex reflects the new page.

Reset
REQ-029 SHALL, while i_rstn=0 at a rising i_clk edge, clear prescaler, debounce, auto and blink counters, page index=0, snapshot=0, debounced button=1 (released).
REQ-030 SHALL drive o_hex=all ones (blank), o_page_led=1 (page 0), o_frozen=0 during and one cycle after reset.
REQ-031 SHALL treat reset asserted mid-debounce or mid-freeze as abandoning that operation; no event is emitted on release.

Configuration
REQ-032 SHALL, with macro BOARD_DEBUG_DISPLAY_BLINK_EN defined, blank all digits of o_hex on alternate BLINK_MS-tick half-periods while frozen, starting visible at freeze entry.
REQ-033 SHALL, without BOARD_DEBUG_DISPLAY_BLINK_EN, show the frozen snapshot steadily and contain no blink counter.

Verification (TICK_DIV=4, DEBOUNCE_MS=2, PAGE_MS=5, BLINK_MS=3, NUM_PAGES=4, NUM_DIGITS=8)
REQ-034 SHALL cover reset: i_rstn=0 for 3 cycles -> o_hex=56'hFF..FF, o_page_led=4'b0001, o_frozen=0.
REQ-035 SHALL cover debounce: button low 1-cycle glitches every 5 cycles -> no page change; held low 20 cycles -> exactly one advance to page 1.
REQ-036 SHALL cover auto wrap: i_auto=1 from page 3 for 20 cycles -> page 0, o_hex shows page-0 nibbles one cycle after o_page_led change.
REQ-037 SHALL cover coincidence: button accept and auto event in same cycle at page 1 -> page 2, not 3.
REQ-038 SHALL cover freeze: page 2 data 32'h12345678 padded, i_freeze=1 then data changed to all F -> o_hex still shows snapshot, button presses ignored; i_freeze=0 -> live F glyphs next cycle.
REQ-039 SHALL cover blink option: with BOARD_DEBUG_DISPLAY_BLINK_EN, frozen for 30 cycles -> o_hex alternates snapshot/all-ones every 12 cycles; without macro, steady snapshot.

Source files
------------

// File: rtl/board_debug_display.sv
// board_debug_display: paged hex viewer for board bring-up. Shows one page of
// NUM_DIGITS nibbles on active-low 7-segment digits; pages advance on a
// debounced push button or a timed auto-rotation, and a freeze input holds a
// snapshot of the current page.
// Optional feature: define BOARD_DEBUG_DISPLAY_BLINK_EN to blink the digits
// while frozen (BLINK_MS ticks visible, BLINK_MS ticks blank).
module board_debug_display #(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned NUM_PAGES   = 4,
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned PAGE_MS     = 2000,
   parameter int unsigned BLINK_MS    = 250
) (
   input  logic                              i_clk,
   input  logic                              i_rstn,
   input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] i_page_data,
   input  logic                              i_btn_next_n,
   input  logic                              i_auto,
   input  logic                              i_freeze,
   output logic [NUM_DIGITS*7-1:0]           o_hex,
   output logic [NUM_PAGES-1:0]              o_page_led,
   output logic                              o_frozen
);

   localparam int unsigned PAGE_W  = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
   localparam int unsigned PRESC_W = $clog2(TICK_DIV + 1);
   localparam int unsigned DEB_W   = $clog2(DEBOUNCE_MS + 1);
   localparam int unsigned AUTO_W  = $clog2(PAGE_MS + 1);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEBOUNCE_MS - 1);
   localparam logic [AUTO_W-1:0]  AUTO_MAX  = AUTO_W'(PAGE_MS - 1);
   localparam logic [PAGE_W-1:0]  PAGE_MAX  = PAGE_W'(NUM_PAGES - 1);

   // Reject configurations the counters and page decode cannot represent.
   if (NUM_PAGES < 2 || NUM_PAGES > 16 || NUM_DIGITS == 0 || TICK_DIV == 0 ||
       DEBOUNCE_MS == 0 || PAGE_MS == 0 || BLINK_MS == 0) begin : g_bad_params
      $error("board_debug_display: parameter out of range");
   end

   logic [PRESC_W-1:0]      presc;
   logic                    tick;
   logic                    btn_meta;
   logic                    btn_sync;
   logic                    btn_db;
   logic [DEB_W-1:0]        deb_cnt;
   logic                    btn_event;
   logic [AUTO_W-1:0]       auto_cnt;
   logic                    auto_event;
   logic                    advance;
   logic [PAGE_W-1:0]       page_idx;
   logic                    frozen;
   logic                    freeze_entry;
   logic                    show_snap;
   logic                    blank_hold;
   logic                    blank_now;
   logic [NUM_DIGITS*4-1:0] live_nibbles;
   logic [NUM_DIGITS*4-1:0] snapshot;
   logic [NUM_DIGITS*4-1:0] shown_nibbles;
   logic [NUM_DIGITS*7-1:0] hex_next;

   // Active-low hex glyphs, bit0 = segment a .. bit6 = segment g.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   assign tick         = (presc == PRESC_MAX);
   assign btn_event    = tick && (btn_sync != btn_db) && (deb_cnt == DEB_MAX) && !btn_sync;
   assign auto_event   = i_auto && tick && (auto_cnt == AUTO_MAX);
   // Coincident events collapse into a single advance; frozen display ignores both.
   assign advance      = (btn_event || auto_event) && !i_freeze;
   assign freeze_entry = i_freeze && !frozen;
   // On the entry cycle live data equals the snapshot being captured.
   assign show_snap    = i_freeze && frozen;
   assign o_frozen     = frozen;

   // Free-running millisecond prescaler.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Two-flop synchronizer for the raw button; idles released.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         btn_meta <= 1'b1;
         btn_sync <= 1'b1;
      end else begin
         btn_meta <= i_btn_next_n;
         btn_sync <= btn_meta;
      end
   end

   // Debounce: a differing level must persist for DEBOUNCE_MS ticks; a bounce back clears.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         btn_db  <= 1'b1;
         deb_cnt <= '0;
      end else if (btn_sync == btn_db) begin
         deb_cnt <= '0;
      end else if (tick) begin
         if (deb_cnt == DEB_MAX) begin
            btn_db  <= btn_sync;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // Auto-rotation timer; restarts when disabled or after a button event.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         auto_cnt <= '0;
      end else if (!i_auto || btn_event) begin
         auto_cnt <= '0;
      end else if (tick) begin
         if (auto_cnt == AUTO_MAX) begin
            auto_cnt <= '0;
         end else begin
            auto_cnt <= auto_cnt + 1'b1;
         end
      end
   end

   // Page index with wrap.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         page_idx <= '0;
      end else if (advance) begin
         page_idx <= (page_idx == PAGE_MAX) ? '0 : page_idx + 1'b1;
      end
   end

   // Freeze tracking and snapshot capture on the first frozen cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         frozen   <= 1'b0;
         snapshot <= '0;
      end else begin
         frozen <= i_freeze;
         if (freeze_entry) begin
            snapshot <= live_nibbles;
         end
      end
   end

`ifdef BOARD_DEBUG_DISPLAY_BLINK_EN
   localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_MS - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_off;

   // Blink phase: starts visible at freeze entry, toggles every BLINK_MS ticks.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (freeze_entry) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (show_snap && tick) begin
         if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign blank_now = show_snap && blink_off;
`else
   assign blank_now = 1'b0;
`endif

   // Select the current page's nibbles and encode the displayed set.
   always_comb begin
      live_nibbles = '0;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         live_nibbles[d*4 +: 4] = i_page_data[(32'(page_idx) * NUM_DIGITS + d) * 4 +: 4];
      end
      shown_nibbles = show_snap ? snapshot : live_nibbles;
      hex_next = '1;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         hex_next[d*7 +: 7] = glyph(shown_nibbles[d*4 +: 4]);
      end
   end

   // Registered display outputs; held blank for one extra cycle after reset.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         blank_hold <= 1'b1;
         o_hex      <= '1;
         o_page_led <= NUM_PAGES'(1);
      end else begin
         blank_hold <= 1'b0;
         o_hex      <= (blank_hold || blank_now) ? '1 : hex_next;
         o_page_led <= NUM_PAGES'(1) << page_idx;
      end
   end

endmodule

// File: tb/tb_board_debug_display.sv
// tb_board_debug_display: directed and randomized stimulus for board_debug_display
// with a behavioural reference model feeding a scoreboard queue; a negedge
// monitor pops and compares every registered output. Follows
// BOARD_DEBUG_DISPLAY_BLINK_EN like the design.
module tb_board_debug_display;

   localparam int NP    = 4;
   localparam int ND    = 8;
   localparam int TICK  = 4;
   localparam int DEB   = 2;
   localparam int PAGE  = 5;
   localparam int BLINK = 3;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct packed {
      logic [ND*7-1:0] hex;
      logic [NP-1:0]   led;
      logic            frz;
   } exp_t;

   logic               clk;
   logic               rstn;
   logic [NP*ND*4-1:0] page_data;
   logic               btn_n;
   logic               auto_en;
   logic               freeze;
   logic [ND*7-1:0]    o_hex;
   logic [NP-1:0]      o_page_led;
   logic               o_frozen;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_shown = 0;

   exp_t sb[$];

   board_debug_display #(
      .NUM_DIGITS  (ND),
      .NUM_PAGES   (NP),
      .TICK_DIV    (TICK),
      .DEBOUNCE_MS (DEB),
      .PAGE_MS     (PAGE),
      .BLINK_MS    (BLINK)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_page_data  (page_data),
      .i_btn_next_n (btn_n),
      .i_auto       (auto_en),
      .i_freeze     (freeze),
      .o_hex        (o_hex),
      .o_page_led   (o_page_led),
      .o_frozen     (o_frozen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ND*7-1:0] hex_of(input logic [ND*4-1:0] nib);
      logic [ND*7-1:0] r;
      for (int d = 0; d < ND; d++) r[d*7 +: 7] = GLYPH[nib[d*4 +: 4]];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) begin
         pass_cnt++;
      end else begin
         if (fail_shown < 40) $display("FAIL %s: got %h expected %h", name, act, req);
         fail_shown++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic press(input int hold, input int rel);
      btn_n = 1'b0;
      repeat (hold) step();
      btn_n = 1'b1;
      repeat (rel) step();
   endtask

   // Reference model state: time since reset, accepted button level, page, freeze.
   int              m_cyc;
   logic            m_b1, m_b2, m_seen;
   logic            m_acc;
   int              m_run;
   int              m_aticks;
   int              m_page;
   logic [ND*4-1:0] m_snap;
   logic [ND*4-1:0] m_live;
   logic            m_prev_frz;
   logic            m_blank;
   logic            m_tick, m_bev, m_aev;
   int              m_fticks;
   exp_t            m_exp;

   always @(posedge clk) begin
      if (!rstn) begin
         m_cyc      = 0;
         m_b1       = 1'b1;
         m_b2       = 1'b1;
         m_acc      = 1'b1;
         m_run      = 0;
         m_aticks   = 0;
         m_page     = 0;
         m_snap     = '0;
         m_prev_frz = 1'b0;
         m_blank    = 1'b1;
         m_fticks   = 0;
         m_exp.hex  = '1;
         m_exp.led  = NP'(1);
         m_exp.frz  = 1'b0;
         sb.push_back(m_exp);
      end else begin
         m_tick = (m_cyc % TICK) == TICK - 1;
         m_live = page_data[m_page*ND*4 +: ND*4];
         // What the display shows after this edge, from the state before it.
         m_exp.hex = hex_of((freeze && m_prev_frz) ? m_snap : m_live);
         if (m_blank) m_exp.hex = '1;
`ifdef BOARD_DEBUG_DISPLAY_BLINK_EN
         if (freeze && m_prev_frz && ((m_fticks / BLINK) % 2 == 1)) m_exp.hex = '1;
`endif
         m_exp.led = NP'(1) << m_page;
         m_exp.frz = freeze;
         sb.push_back(m_exp);

         // Button level reaching the debouncer is the raw level two edges old.
         m_seen = m_b2;
         m_b2   = m_b1;
         m_b1   = btn_n;
         m_bev  = 1'b0;
         if (m_seen == m_acc) begin
            m_run = 0;
         end else if (m_tick) begin
            m_run++;
            if (m_run >= DEB) begin
               m_acc = m_seen;
               m_run = 0;
               m_bev = (m_seen == 1'b0);
            end
         end

         m_aev = 1'b0;
         if (!auto_en) begin
            m_aticks = 0;
         end else if (m_tick) begin
            m_aticks++;
            if (m_aticks == PAGE) begin
               m_aev    = 1'b1;
               m_aticks = 0;
            end
         end
         if (m_bev) m_aticks = 0;

         if ((m_bev || m_aev) && !freeze) m_page = (m_page + 1) % NP;

         if (freeze && !m_prev_frz) begin
            m_snap   = m_live;
            m_fticks = 0;
         end
`ifdef BOARD_DEBUG_DISPLAY_BLINK_EN
         else if (freeze && m_prev_frz && m_tick) begin
            m_fticks++;
         end
`endif
         m_prev_frz = freeze;
         m_blank    = 1'b0;
         m_cyc++;
      end
   end

   exp_t mon_exp;

   // Monitor: every output cycle is compared against the queued expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_exp = sb.pop_front();
         check("scoreboard", 64'({o_hex, o_page_led, o_frozen}), 64'(mon_exp));
      end
   end

   initial begin
      rstn      = 1'b0;
      btn_n     = 1'b1;
      auto_en   = 1'b0;
      freeze    = 1'b0;
      page_data = {$urandom, $urandom, $urandom, $urandom};

      // Reset held for three cycles, then one blank cycle after release.
      repeat (3) step();
      @(negedge clk);
      check("reset_hex", 64'(o_hex), {8'h00, {ND*7{1'b1}}});
      check("reset_led", 64'(o_page_led), 64'(4'b0001));
      check("reset_frozen", 64'(o_frozen), 64'(0));
      rstn = 1'b1;
      step();
      @(negedge clk);
      check("post_reset_hex", 64'(o_hex), {8'h00, {ND*7{1'b1}}});

      // Short glitches never survive the debounce window.
      for (int i = 0; i < 40; i++) begin
         btn_n = (i % 5 == 0) ? 1'b0 : 1'b1;
         step();
      end
      btn_n = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check("glitch_no_advance", 64'(o_page_led), 64'(4'b0001));

      // A long press gives exactly one advance.
      press(20, 20);
      @(negedge clk);
      check("press_page1", 64'(o_page_led), 64'(4'b0010));
      press(20, 20);
      press(20, 20);
      @(negedge clk);
      check("press_page3", 64'(o_page_led), 64'(4'b1000));

      // Auto rotation wraps page 3 to page 0.
      auto_en = 1'b1;
      repeat (20) step();
      auto_en = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("auto_wrap_led", 64'(o_page_led), 64'(4'b0001));
      check("auto_wrap_hex", 64'(o_hex), 64'(hex_of(page_data[0 +: ND*4])));

      press(20, 20);
      @(negedge clk);
      check("press_page1_again", 64'(o_page_led), 64'(4'b0010));

      // Line auto enable up with a tick so its fifth tick meets the button accept.
      while ((m_cyc % TICK) != TICK - 1) step();
      auto_en = 1'b1;
      repeat (10) step();
      btn_n = 1'b0;
      repeat (10) step();
      auto_en = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("coincide_page2", 64'(o_page_led), 64'(4'b0100));
      btn_n = 1'b1;
      repeat (20) step();

      // Freeze page 2, change data, press: snapshot held, page unchanged.
      page_data[2*ND*4 +: ND*4] = 32'h12345678;
      step();
      freeze = 1'b1;
      repeat (2) step();
      page_data = '1;
      repeat (3) step();
      press(20, 20);
      @(negedge clk);
`ifndef BOARD_DEBUG_DISPLAY_BLINK_EN
      check("frozen_hex", 64'(o_hex), 64'(hex_of(32'h12345678)));
`endif
      check("frozen_led", 64'(o_page_led), 64'(4'b0100));
      check("frozen_flag", 64'(o_frozen), 64'(1));
      freeze = 1'b0;
      step();
      @(negedge clk);
      check("unfreeze_hex", 64'(o_hex), {8'h00, {ND{7'h0E}}});
      check("unfreeze_flag", 64'(o_frozen), 64'(0));

      // Randomized segments, including mid-operation resets.
      for (int s = 0; s < 120; s++) begin
         int unsigned len;
         len   = $urandom_range(1, 30);
         btn_n = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 11) == 0) freeze = ~freeze;
         if ($urandom_range(0, 4) == 0) page_data = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 49) == 0) begin
            rstn = 1'b0;
            repeat (2) step();
            rstn = 1'b1;
         end
         repeat (len) step();
      end

      repeat (2) step();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
